// File: rtl/reg_file.sv
// Two-read / one-write register file with write-before-read bypass, hard-wired
// zero register and a saturating count of committed writes.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            read_reg1,
  input  logic [4:0]            read_reg2,
  input  logic [4:0]            write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  regwrite,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  output logic [7:0]            write_count
);

  localparam logic [5:0] REG_LIMIT = 6'(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];
  logic [7:0]            write_count_reg;
  logic                  write_en;
  logic [NUM_REGS-1:0]   wr_sel;
  logic                  valid1;
  logic                  valid2;
  logic                  bypass1;
  logic                  bypass2;

  // A write commits only to an existing, non-zero register.
  assign write_en = regwrite && (write_reg != 5'd0) && ({1'b0, write_reg} < REG_LIMIT);

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sel
      if (gi == 0) begin : g_zero
        assign wr_sel[gi] = 1'b0;
      end else begin : g_nonzero
        assign wr_sel[gi] = write_en && (write_reg == 5'(gi));
      end
    end
  endgenerate

  // Flop storage rather than RAM: every entry must clear asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel[i]) begin
          regs_reg[i] <= write_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_count_reg <= 8'd0;
    end else if (write_en && (write_count_reg != 8'hFF)) begin
      write_count_reg <= write_count_reg + 8'd1;
    end
  end

  assign write_count = write_count_reg;

  // Bypass is suppressed during reset so reads stay at zero.
  assign valid1  = !reset && (read_reg1 != 5'd0) && ({1'b0, read_reg1} < REG_LIMIT);
  assign valid2  = !reset && (read_reg2 != 5'd0) && ({1'b0, read_reg2} < REG_LIMIT);
  assign bypass1 = write_en && (write_reg == read_reg1);
  assign bypass2 = write_en && (write_reg == read_reg2);

  always_comb begin
    read_data1 = '0;
    if (valid1) begin
      read_data1 = bypass1 ? write_data : regs_reg[read_reg1];
    end
  end

  always_comb begin
    read_data2 = '0;
    if (valid2) begin
      read_data2 = bypass2 ? write_data : regs_reg[read_reg2];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed plus randomized checks of reg_file against an array-based model.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  read_reg1 = '0;
  logic [4:0]  read_reg2 = '0;
  logic [4:0]  write_reg = '0;
  logic [31:0] write_data = '0;
  logic        regwrite = 1'b0;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [7:0]  write_count;

  reg_file #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .regwrite   (regwrite),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .write_count(write_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] mem [32];
  int          cnt_model = 0;

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (reset || a == 5'd0) return 32'd0;
    if (regwrite && write_reg != 5'd0 && write_reg == a) return write_data;
    return mem[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    cnt_model = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction: drive at negedge, check reads, clock, check count.
  task automatic txn(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] w,
                     input logic [31:0] d, input logic we);
    @(negedge clk);
    read_reg1 = r1; read_reg2 = r2; write_reg = w; write_data = d; regwrite = we;
    #1;
    check("rd1", read_data1, model_read(r1));
    check("rd2", read_data2, model_read(r2));
    @(posedge clk);
    if (!reset && we && w != 5'd0) begin
      mem[w] = d;
      if (cnt_model < 255) cnt_model++;
    end
    #1;
    check("wcnt", {24'd0, write_count}, 32'(cnt_model));
    $display("txn t=%0t we=%0b wr=%0d wd=%h r1=%0d rd1=%h r2=%0d rd2=%h cnt=%0d",
             $time, we, w, d, r1, read_data1, r2, read_data2, write_count);
  endtask

  initial begin
    logic [4:0]  r1, r2, w;
    logic [31:0] d;

    model_clear();
    #2 reset = 1'b1;
    #1;
    check("rst_cnt", {24'd0, write_count}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // All addresses read zero after reset.
    for (int i = 0; i < 32; i++) txn(5'(i), 5'(31 - i), 5'd0, 32'd0, 1'b0);

    // Basic write then read back.
    txn(5'd0, 5'd0, 5'd8, 32'hDEADBEEF, 1'b1);
    txn(5'd8, 5'd0, 5'd0, 32'd0, 1'b0);

    // Writes to register 0 are dropped.
    txn(5'd0, 5'd0, 5'd0, 32'h12345678, 1'b1);
    txn(5'd8, 5'd0, 5'd0, 32'd0, 1'b0);

    // Dual-port bypass, then stored value.
    txn(5'd5, 5'd5, 5'd5, 32'hA5A5A5A5, 1'b1);
    txn(5'd5, 5'd5, 5'd0, 32'd0, 1'b0);

    // Randomized traffic with frequent read/write address collisions.
    for (int i = 0; i < 150; i++) begin
      r1 = 5'($urandom_range(0, 31));
      r2 = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0: w = r1;
        1: w = r2;
        default: w = 5'($urandom_range(0, 31));
      endcase
      d = $urandom;
      txn(r1, r2, w, d, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in mid-cycle with a write pending.
    txn(5'd0, 5'd0, 5'd31, 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    read_reg1 = 5'd31; read_reg2 = 5'd31; write_reg = 5'd31;
    write_data = 32'h11111111; regwrite = 1'b1;
    #1;
    check("pre_rst_byp", read_data1, 32'h11111111);
    #1 reset = 1'b1;
    #1;
    model_clear();
    check("async_rd1", read_data1, 32'd0);
    check("async_rd2", read_data2, 32'd0);
    check("async_cnt", {24'd0, write_count}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_edge_rd1", read_data1, 32'd0);
    @(negedge clk);
    reset = 1'b0; regwrite = 1'b0;
    #1;
    check("rst_blocked_wr", read_data1, 32'd0);
    check("rst_blocked_cnt", {24'd0, write_count}, 32'd0);
    txn(5'd31, 5'd0, 5'd2, 32'h0BADF00D, 1'b1);
    txn(5'd2, 5'd31, 5'd0, 32'd0, 1'b0);

    // Saturation of write_count.
    for (int i = 0; i < 300; i++) txn(5'd1, 5'd2, 5'd1, $urandom, 1'b1);
    txn(5'd1, 5'd1, 5'd0, 32'd0, 1'b0);
    check("sat_cnt", {24'd0, write_count}, 32'd255);

    // Reset clears the saturated count; writes resume immediately after.
    @(negedge clk) reset = 1'b1;
    #1;
    model_clear();
    check("sat_rst_cnt", {24'd0, write_count}, 32'd0);
    @(negedge clk) reset = 1'b0;
    txn(5'd0, 5'd0, 5'd3, 32'hCAFEF00D, 1'b1);
    txn(5'd3, 5'd1, 5'd0, 32'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
